// File: rtl/seq_scan_pkg.sv
// Shared types and default sizes for the serial pattern-scan controller.
package seq_scan_pkg;

    localparam int DATA_W_DEF  = 16;
    localparam int PAT_MAX_DEF = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/seq_scan_ctrl_if.sv
// Control/status bundle between software-facing logic and the scan controller.
interface seq_scan_ctrl_if
    import seq_scan_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PAT_MAX = PAT_MAX_DEF,
    parameter int CNT_W   = $clog2(DATA_W + 1),
    parameter int LEN_W   = $clog2(PAT_MAX + 1)
);

    logic              start;
    logic [DATA_W-1:0] data_in;
    logic [PAT_MAX-1:0] pat;
    logic [LEN_W-1:0]  pat_len;
    logic              overlap;

    logic              busy;
    logic              done;
    logic              bit_out;
    logic              match;
    logic [CNT_W-1:0]  match_cnt;
    logic              first_vld;
    logic [CNT_W-1:0]  first_pos;

    modport master (
        output start, data_in, pat, pat_len, overlap,
        input  busy, done, bit_out, match,
        input  match_cnt, first_vld, first_pos
    );

    modport slave (
        input  start, data_in, pat, pat_len, overlap,
        output busy, done, bit_out, match,
        output match_cnt, first_vld, first_pos
    );

endinterface

// File: rtl/seq_window_match.sv
// Sliding history window with masked compare against a programmable pattern.
module seq_window_match #(
    parameter int PAT_MAX = 4,
    parameter int LEN_W   = $clog2(PAT_MAX + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               bit_in,
    input  logic               shift_en,
    input  logic               clear,
    input  logic [LEN_W-1:0]   len,
    input  logic [PAT_MAX-1:0] pat,
    input  logic               overlap,
    output logic               match
);

    logic [PAT_MAX-2:0] hist;
    logic [LEN_W-1:0]   valid;
    logic [PAT_MAX-1:0] window;
    logic [PAT_MAX-1:0] mask;
    logic [LEN_W:0]     seen;

    assign window = {hist, bit_in};
    assign seen   = {1'b0, valid} + {{LEN_W{1'b0}}, 1'b1};

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_MAX; i++) begin
            mask[i] = (i < int'(len));
        end
    end

    // seen counts the incoming bit, so a match can complete on it
    assign match = (len != '0)
                && (seen >= {1'b0, len})
                && ((window & mask) == (pat & mask));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hist  <= '0;
            valid <= '0;
        end else if (clear) begin
            hist  <= '0;
            valid <= '0;
        end else if (shift_en) begin
            hist <= window[PAT_MAX-2:0];
            if (match && !overlap) begin
                valid <= '0;
            end else if (valid != LEN_W'(PAT_MAX)) begin
                valid <= valid + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_scan_ctrl.sv
// Scan controller: shifts a latched word MSB first through the window matcher
// and accumulates match count and first-match position.
module seq_scan_ctrl
    import seq_scan_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int PAT_MAX = PAT_MAX_DEF,
    parameter int CNT_W   = $clog2(DATA_W + 1),
    parameter int LEN_W   = $clog2(PAT_MAX + 1)
) (
    input  logic            clk,
    input  logic            reset,
    seq_scan_ctrl_if.slave  bus
);

    localparam int IDX_W = $clog2(DATA_W);

    state_t state;
    state_t nxt;

    logic               accept;
    logic               shifting;
    logic               fin;
    logic               busy_c;
    logic               last;
    logic               hit;

    logic [DATA_W-1:0]  word;
    logic [PAT_MAX-1:0] pat_r;
    logic [LEN_W-1:0]   len_r;
    logic [LEN_W-1:0]   len_c;
    logic               ovl_r;
    logic [IDX_W-1:0]   idx;
    logic [CNT_W-1:0]   cnt;
    logic               fvld;
    logic [CNT_W-1:0]   fpos;

    assign last  = (idx == IDX_W'(DATA_W - 1));
    assign len_c = (bus.pat_len > LEN_W'(PAT_MAX))
                 ? LEN_W'(PAT_MAX) : bus.pat_len;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nxt;
    end

    always_comb begin
        nxt      = state;
        accept   = 1'b0;
        shifting = 1'b0;
        fin      = 1'b0;
        busy_c   = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    accept = 1'b1;
                    nxt    = SHIFT;
                end
            end
            SHIFT: begin
                busy_c   = 1'b1;
                shifting = 1'b1;
                if (last) nxt = DONE;
            end
            DONE: begin
                busy_c = 1'b1;
                fin    = 1'b1;
                nxt    = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // The word register shifts left, so its MSB is always the current bit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word  <= '0;
            pat_r <= '0;
            len_r <= '0;
            ovl_r <= 1'b0;
            idx   <= '0;
            cnt   <= '0;
            fvld  <= 1'b0;
            fpos  <= '0;
        end else if (accept) begin
            word  <= bus.data_in;
            pat_r <= bus.pat;
            len_r <= len_c;
            ovl_r <= bus.overlap;
            idx   <= '0;
            cnt   <= '0;
            fvld  <= 1'b0;
            fpos  <= '0;
        end else if (shifting) begin
            word <= word << 1;
            idx  <= idx + 1'b1;
            if (hit) begin
                cnt <= cnt + 1'b1;
                if (!fvld) begin
                    fvld <= 1'b1;
                    fpos <= CNT_W'(idx);
                end
            end
        end
    end

    seq_window_match #(
        .PAT_MAX (PAT_MAX),
        .LEN_W   (LEN_W)
    ) u_win (
        .clk      (clk),
        .reset    (reset),
        .bit_in   (word[DATA_W-1]),
        .shift_en (shifting),
        .clear    (accept),
        .len      (len_r),
        .pat      (pat_r),
        .overlap  (ovl_r),
        .match    (hit)
    );

    assign bus.busy      = busy_c;
    assign bus.done      = fin;
    assign bus.bit_out   = shifting & word[DATA_W-1];
    assign bus.match     = shifting & hit;
    assign bus.match_cnt = cnt;
    assign bus.first_vld = fvld;
    assign bus.first_pos = fpos;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Self-checking bench for seq_scan_ctrl with a bit-list reference model.
module tb_seq_scan_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    seq_scan_ctrl_if bus ();

    seq_scan_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Match vector: bit i set when scan bit i (0 = MSB) completes a match
    function automatic logic [15:0] model(input logic [15:0] d,
                                          input logic [3:0] p,
                                          input int len_in,
                                          input bit ovl);
        logic [15:0] r;
        int base;
        int l;
        bit m;
        r = '0;
        base = 0;
        l = (len_in > 4) ? 4 : len_in;
        for (int i = 0; i < 16; i++) begin
            m = (l > 0) && (i - base + 1 >= l);
            for (int j = 0; j < l; j++) begin
                if (m && (d[15-(i-j)] !== p[j])) m = 1'b0;
            end
            if (m) begin
                r[i] = 1'b1;
                if (!ovl) base = i + 1;
            end
        end
        return r;
    endfunction

    task automatic scramble(input bit hold);
        bus.start   = hold;
        bus.data_in = 16'($urandom);
        bus.pat     = 4'($urandom);
        bus.pat_len = 3'($urandom);
        bus.overlap = 1'($urandom);
    endtask

    task automatic run_scan(input string name, input logic [15:0] d,
                            input logic [3:0] p, input logic [2:0] l,
                            input bit ovl, input bit hold);
        logic [15:0] ev;
        int ecnt;
        int efirst;
        ev = model(d, p, int'(l), ovl);
        ecnt = 0;
        efirst = 0;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = d;
        bus.pat     = p;
        bus.pat_len = l;
        bus.overlap = ovl;
        @(posedge clk);
        #1;
        for (int k = 0; k < 16; k++) begin
            checks++;
            if ({bus.busy, bus.done, bus.bit_out, bus.match}
                !== {1'b1, 1'b0, d[15-k], ev[k]}) begin
                errors++;
                $display("FAIL %s bit%0d busy/done/bit/match got %b%b%b%b want 10%b%b",
                         name, k, bus.busy, bus.done, bus.bit_out, bus.match,
                         d[15-k], ev[k]);
            end
            checks++;
            if ({bus.match_cnt, bus.first_vld, bus.first_pos}
                !== {5'(ecnt), (ecnt > 0), 5'(efirst)}) begin
                errors++;
                $display("FAIL %s bit%0d cnt/vld/pos got %0d/%b/%0d want %0d/%b/%0d",
                         name, k, bus.match_cnt, bus.first_vld, bus.first_pos,
                         ecnt, (ecnt > 0), efirst);
            end
            if (ev[k]) begin
                if (ecnt == 0) efirst = k;
                ecnt++;
            end
            @(negedge clk);
            scramble(hold);
            @(posedge clk);
            #1;
        end
        checks++;
        if ({bus.busy, bus.done, bus.bit_out, bus.match} !== 4'b1100) begin
            errors++;
            $display("FAIL %s done-cycle busy/done/bit/match got %b%b%b%b want 1100",
                     name, bus.busy, bus.done, bus.bit_out, bus.match);
        end
        checks++;
        if ({bus.match_cnt, bus.first_vld, bus.first_pos}
            !== {5'(ecnt), (ecnt > 0), 5'(efirst)}) begin
            errors++;
            $display("FAIL %s result cnt/vld/pos got %0d/%b/%0d want %0d/%b/%0d",
                     name, bus.match_cnt, bus.first_vld, bus.first_pos,
                     ecnt, (ecnt > 0), efirst);
        end
        @(negedge clk);
        scramble(hold);
        @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.bit_out, bus.match,
             bus.match_cnt, bus.first_vld, bus.first_pos}
            !== {4'b0000, 5'(ecnt), (ecnt > 0), 5'(efirst)}) begin
            errors++;
            $display("FAIL %s idle-hold got b%b d%b cnt%0d vld%b pos%0d want cnt%0d",
                     name, bus.busy, bus.done, bus.match_cnt,
                     bus.first_vld, bus.first_pos, ecnt);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b1;
        bus.data_in = 16'hFFFF;
        bus.pat = 4'hF;
        bus.pat_len = 3'd1;
        bus.overlap = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.bit_out, bus.match,
             bus.match_cnt, bus.first_vld, bus.first_pos} !== '0) begin
            errors++;
            $display("FAIL reset outputs got b%b d%b bo%b m%b cnt%0d vld%b pos%0d want 0",
                     bus.busy, bus.done, bus.bit_out, bus.match,
                     bus.match_cnt, bus.first_vld, bus.first_pos);
        end
        @(negedge clk);
        bus.start = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.match_cnt} !== '0) begin
            errors++;
            $display("FAIL post_reset_idle got busy%b done%b cnt%0d want 0",
                     bus.busy, bus.done, bus.match_cnt);
        end
    endtask

    task automatic test_directed();
        run_scan("alt01", 16'h5555, 4'b0001, 3'd2, 1'b1, 1'b0);
        run_scan("ones_ovl", 16'hFFFF, 4'b0111, 3'd3, 1'b1, 1'b0);
        run_scan("ones_novl", 16'hFFFF, 4'b0111, 3'd3, 1'b0, 1'b0);
        run_scan("len0", 16'hFFFF, 4'b1111, 3'd0, 1'b1, 1'b0);
        run_scan("p1001_hi", 16'h9000, 4'b1001, 3'd4, 1'b1, 1'b0);
        run_scan("p1001_lo", 16'h0009, 4'b1001, 3'd4, 1'b1, 1'b0);
        run_scan("len_clamp", 16'hF0F3, 4'b0011, 3'd7, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] d;
        logic [3:0] p;
        for (int n = 0; n < 24; n++) begin
            p = 4'($urandom);
            if (n % 3 == 0) d = {4{p}};
            else            d = 16'($urandom);
            run_scan("rand", d, p, 3'($urandom_range(0, 7)),
                     1'($urandom), 1'b0);
        end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 5; n++) begin
            run_scan("b2b", 16'($urandom), 4'($urandom),
                     3'($urandom_range(1, 4)), 1'($urandom), 1'b1);
        end
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit seen_bad;
        @(negedge clk);
        bus.start   = 1'b1;
        bus.data_in = 16'h5555;
        bus.pat     = 4'b0001;
        bus.pat_len = 3'd2;
        bus.overlap = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        checks++;
        if ({bus.match, bus.match_cnt} !== {1'b1, 5'd3}) begin
            errors++;
            $display("FAIL mid_pre match/cnt got %b/%0d want 1/3",
                     bus.match, bus.match_cnt);
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.bit_out, bus.match,
             bus.match_cnt, bus.first_vld, bus.first_pos} !== '0) begin
            errors++;
            $display("FAIL mid_reset got b%b d%b bo%b m%b cnt%0d vld%b pos%0d want 0",
                     bus.busy, bus.done, bus.bit_out, bus.match,
                     bus.match_cnt, bus.first_vld, bus.first_pos);
        end
        @(negedge clk);
        reset = 1'b0;
        seen_bad = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.done || bus.busy) seen_bad = 1'b1;
        end
        checks++;
        if (seen_bad !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_done got busy/done activity %b want 0", seen_bad);
        end
        run_scan("after_reset", 16'h9009, 4'b1001, 3'd4, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout got running want finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_scan_ctrl.md
Name: seq_scan_ctrl

Overview:
- Controller that sequences a bit-serial pattern detector over a parallel data word.
- Accepts a word plus a programmable pattern through a start/busy/done handshake, then shifts the word out MSB first, one bit per cycle.
- Detects the pattern Mealy-style, counts matches and records the first match position.
- Sits between register-mapped software control and the serial detector datapath; generalises the fixed "01" detectors to a configurable pattern.

Parameters:
- DATA_W, 16, width of the scanned word (bits shifted per operation).
- PAT_MAX, 4, maximum pattern length in bits.
- CNT_W, $clog2(DATA_W+1), width of the count and position outputs.
- LEN_W, $clog2(PAT_MAX+1), width of pat_len.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request a scan; accepted only in IDLE.
- data_in  input  DATA_W  word to scan; sampled at accept.
- pat  input  PAT_MAX  pattern; bit 0 = most recent serial bit; sampled at accept.
- pat_len  input  LEN_W  pattern length, 0..PAT_MAX; sampled at accept.
- overlap  input  1  1 = overlapping matches allowed; sampled at accept.
- busy  output  1  high in SHIFT and DONE.
- done  output  1  one-cycle pulse at end of scan.
- bit_out  output  1  serial bit currently scanned; 0 outside SHIFT.
- match  output  1  high in the SHIFT cycle whose bit completes a match.
- match_cnt  output  CNT_W  matches in the current/last scan.
- first_vld  output  1  at least one match has occurred in this scan.
- first_pos  output  CNT_W  bit index (0 = MSB) of the bit that completed the first match.

Behaviour:
- Reset (asynchronous, active-high; clock clk): state=IDLE. busy, done, bit_out, match, match_cnt, first_vld, first_pos all 0. History and index cleared.
- States: IDLE, SHIFT, DONE; 2-bit encoding.
- IDLE:
  - On start=1, latch data_in, pat, pat_len (values >PAT_MAX clamp to PAT_MAX) and overlap.
  - Clear match_cnt, first_vld, first_pos, history and history-valid count; set idx=0.
  - Next state SHIFT.
- SHIFT:
  - bit_out = word[DATA_W-1-idx].
  - window = {hist, bit_out}, masked to the low pat_len bits.
  - match = (len_eff != 0) && (valid+1 >= len_eff) && (window == pat[len_eff-1:0]). Combinational in the same cycle as bit_out.
  - On match: match_cnt+1. If first_vld=0, set first_vld=1 and first_pos=idx.
  - If overlap=0, a match clears history-valid to 0; otherwise valid saturates at PAT_MAX.
  - idx+1 each cycle. At idx=DATA_W-1, next state DONE.
- DONE: done=1 for exactly one cycle; busy stays 1; next state IDLE.
- Latency: start accepted at cycle T; bits appear in cycles T+1..T+DATA_W; done at T+DATA_W+1. Back-to-back scans occur every DATA_W+2 cycles.
- start in SHIFT or DONE is ignored. Changes to the input ports during a scan have no effect.
- match_cnt, first_vld and first_pos hold after DONE until the next accepted start.
- No overflow: match_cnt never exceeds DATA_W, which fits in CNT_W.
- History is cleared on every accept, so no match spans two scans.
- Reset mid-scan aborts immediately to reset values, with no done pulse.

Decomposition:
- Package seq_scan_pkg:
  - state_t enum {IDLE, SHIFT, DONE}.
  - Default DATA_W and PAT_MAX localparams.
- One sub-module, seq_window_match:
  - Contains the history shift register, the valid counter and the masked comparator.
  - Inputs: bit_in, shift_en, clear, len, pat, overlap.
  - Output: match.
- The top level holds the FSM, index counter, word register, count and first-position logic.

Test Plan:
- DATA_W=16, pat=2'b01, pat_len=2, overlap=1, data=16'h5555 -> match at idx 1,3,...,15; match_cnt=8; first_pos=1; done 17 cycles after accept.
- data=16'hFFFF, pat=3'b111, pat_len=3: overlap=1 -> match_cnt=14, first_pos=2. overlap=0 -> matches at idx 2,5,8,11,14, match_cnt=5.
- pat_len=0, data=16'hFFFF -> match never asserts; match_cnt=0; first_vld=0; done still pulses at +17.
- pat=4'b1001, pat_len=4, data=16'h9000 -> single match at idx 3; match_cnt=1; first_pos=3.
- Next scan data=16'h0009, same pattern -> match only at idx 15 (no leakage from the prior scan's history).
- start held high continuously; data_in toggled mid-scan -> accepts exactly every 18 cycles; results reflect only the words latched at accept.
- reset pulsed at idx 7 of a scan -> busy, bit_out, match, match_cnt, first_vld all 0 within the same cycle; no done pulse; a following start completes normally.
